// File: rtl/pipelined_prefix_subtractor.sv
// pipelined_prefix_subtractor
//   Pipelined Kogge-Stone subtractor: diff = a - b computed as a + ~b + 1.
//   There is one register rank per prefix level, followed by a result
//   register. An operand accepted on edge N is presented on the outputs
//   after edge N+LEVELS. A valid/ready handshake stalls the whole pipe.
//
// Parameters
//   WIDTH   operand/result width (power of two, >= 4)
//   LEVELS  prefix levels = log2(WIDTH)
//
// Ports
//   clk        rising-edge clock
//   clear      asynchronous active-high reset; discards all in-flight ops
//   in_valid   a/b valid this cycle
//   in_ready   block accepts a/b this cycle
//   a, b       minuend, subtrahend
//   out_valid  diff/flags valid; held with stable data until out_ready
//   out_ready  downstream accepts the result this cycle
//   diff       a - b mod 2^WIDTH
//   borrow     a < b unsigned (inverted carry out)
//   zero       diff == 0
//   negative   diff sign bit
//   overflow   signed overflow of the subtraction
module pipelined_prefix_subtractor #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LEVELS = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  // A stalled output freezes every rank, so nothing advances and no
  // bubble is compressed out of the pipe.
  logic stall;

  // Stage 0 generate/propagate of a + ~b
  logic [WIDTH-1:0] s0_g;
  logic [WIDTH-1:0] s0_p;

  // Output register rank
  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;
  logic             negative_q;
  logic             overflow_q;

  // Result computed from the final prefix rank
  logic [WIDTH-1:0] fin_c;
  logic [WIDTH-1:0] res_diff;
  logic             res_borrow;
  logic             res_zero;
  logic             res_negative;
  logic             res_overflow;
  logic             fin_vld;
  logic             fin_sa;
  logic             fin_sb;
  logic [WIDTH-1:0] fin_pb;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // The fixed carry-in of 1 is folded into bit 0 here, so after the
  // prefix tree every G bit i is the carry out of position i directly.
  always_comb begin
    s0_p    = a ^ ~b;
    s0_g    = a & ~b;
    s0_g[0] = s0_g[0] | s0_p[0];
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned DIST = 32'd1 << (k - 1);

    logic [WIDTH-1:0] src_g;
    logic [WIDTH-1:0] src_p;
    logic [WIDTH-1:0] src_pb;
    logic             src_vld;
    logic             src_sa;
    logic             src_sb;

    logic [WIDTH-1:0] nxt_g;
    logic [WIDTH-1:0] nxt_p;

    // Rank registers for this level
    logic [WIDTH-1:0] rank_g;
    logic [WIDTH-1:0] rank_p;
    logic [WIDTH-1:0] rank_pb;   // original half-sum bits, needed for diff
    logic             rank_vld;
    logic             rank_sa;
    logic             rank_sb;

    if (k == 1) begin : g_first
      assign src_g   = s0_g;
      assign src_p   = s0_p;
      assign src_pb  = s0_p;
      assign src_vld = in_valid;
      assign src_sa  = a[WIDTH-1];
      assign src_sb  = b[WIDTH-1];
    end else begin : g_rest
      assign src_g   = g_lvl[k-1].rank_g;
      assign src_p   = g_lvl[k-1].rank_p;
      assign src_pb  = g_lvl[k-1].rank_pb;
      assign src_vld = g_lvl[k-1].rank_vld;
      assign src_sa  = g_lvl[k-1].rank_sa;
      assign src_sb  = g_lvl[k-1].rank_sb;
    end

    // Combine with the span DIST positions below. Bits under DIST already
    // hold their final carry and pass through unchanged.
    always_comb begin
      nxt_g = src_g;
      nxt_p = src_p;
      nxt_g[WIDTH-1:DIST] = src_g[WIDTH-1:DIST]
                          | (src_p[WIDTH-1:DIST] & src_g[WIDTH-1-DIST:0]);
      nxt_p[WIDTH-1:DIST] = src_p[WIDTH-1:DIST] & src_p[WIDTH-1-DIST:0];
    end

    always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
        rank_g   <= '0;
        rank_p   <= '0;
        rank_pb  <= '0;
        rank_vld <= 1'b0;
        rank_sa  <= 1'b0;
        rank_sb  <= 1'b0;
      end else if (!stall) begin
        rank_g   <= nxt_g;
        rank_p   <= nxt_p;
        rank_pb  <= src_pb;
        rank_vld <= src_vld;
        rank_sa  <= src_sa;
        rank_sb  <= src_sb;
      end
    end
  end

  assign fin_c   = g_lvl[LEVELS].rank_g;
  assign fin_pb  = g_lvl[LEVELS].rank_pb;
  assign fin_vld = g_lvl[LEVELS].rank_vld;
  assign fin_sa  = g_lvl[LEVELS].rank_sa;
  assign fin_sb  = g_lvl[LEVELS].rank_sb;

  // diff_i = p_i ^ c_(i-1); the carry into bit 0 is the constant 1.
  always_comb begin
    res_diff     = fin_pb ^ {fin_c[WIDTH-2:0], 1'b1};
    res_borrow   = ~fin_c[WIDTH-1];
    res_zero     = ~|res_diff;
    res_negative = res_diff[WIDTH-1];
    res_overflow = (fin_sa ^ fin_sb) & (res_diff[WIDTH-1] ^ fin_sa);
  end

  // Data of invalid ranks is arbitrary, so the result register loads
  // zeros for bubbles to keep outputs at 0 whenever out_valid is 0.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= fin_vld;
      diff_q      <= fin_vld ? res_diff : '0;
      borrow_q    <= fin_vld & res_borrow;
      zero_q      <= fin_vld & res_zero;
      negative_q  <= fin_vld & res_negative;
      overflow_q  <= fin_vld & res_overflow;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_prefix_subtractor.sv
module tb_pipelined_prefix_subtractor;
  localparam int unsigned W = 32;
  localparam int unsigned L = 5;

  logic         clk = 1'b0;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         negative;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  pipelined_prefix_subtractor #(.WIDTH(W), .LEVELS(L)) dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .zero(zero), .negative(negative),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bo;
    logic        z;
    logic        n;
    logic        o;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic [31:0] exp_q [$];
    logic        expb_q [$];
    int issued;
    int got;
    int stall_seen;
    int valid_seen;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h0234_5679, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};

    sa = '{32'h0000_0010, 32'h0000_0001, 32'hCAFE_F00D, 32'h7FFF_FFFF,
           32'h0000_0000, 32'h8000_0001, 32'h1111_1111, 32'hFFFF_0000};
    sb = '{32'h0000_0001, 32'h0000_0010, 32'h1234_5678, 32'h8000_0000,
           32'hFFFF_FFFF, 32'h0000_0002, 32'h1111_1111, 32'h0000_FFFF};

    // Reset state
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_diff", diff, 32'd0);
    chk("rst_flags", {28'd0, borrow, zero, negative, overflow}, 32'd0);
    tick(); tick();
    clear = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven single operations with latency check
    for (int i = 0; i < 10; i++) begin
      a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0; a = '0; b = '0;
      for (int c = 1; c < int'(L); c++) begin
        tick();
        chk($sformatf("v%0d_early_valid_c%0d", i, c), {31'd0, out_valid}, 32'd0);
      end
      tick();
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_diff", i), diff, vecs[i].d);
      chk($sformatf("v%0d_borrow", i), {31'd0, borrow}, {31'd0, vecs[i].bo});
      chk($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_negative", i), {31'd0, negative}, {31'd0, vecs[i].n});
      chk($sformatf("v%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].o});
      tick();
      chk($sformatf("v%0d_retired", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_gated_diff", i), diff, 32'd0);
    end

    // Back-to-back stream with a three-cycle output stall
    issued = 0; got = 0; stall_seen = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 7 && cyc <= 9);
      in_valid  = (issued < 8);
      a = (issued < 8) ? sa[issued] : '0;
      b = (issued < 8) ? sb[issued] : '0;
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra_output", diff, 32'hXXXX_XXXX);
        end else begin
          chk($sformatf("stream_diff_%0d", got), diff, exp_q[0]);
          chk($sformatf("stream_borrow_%0d", got), {31'd0, borrow}, {31'd0, expb_q[0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(expb_q.pop_front());
            got++;
          end else begin
            stall_seen++;
            chk($sformatf("stall_in_ready_c%0d", cyc), {31'd0, in_ready}, 32'd0);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(a - b);
        expb_q.push_back(a < b);
        issued++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_issued", issued, 32'd8);
    chk("stream_received", got, 32'd8);
    chk("stream_stall_cycles", stall_seen, 32'd3);
    valid_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) valid_seen++;
    end
    chk("stream_no_duplicates", valid_seen, 32'd0);

    // Clear with three operations in flight
    for (int i = 0; i < 3; i++) begin
      a = 32'h0000_0100 + i; b = 32'h0000_0001; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    #2 clear = 1'b1;
    #1;
    chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_diff", diff, 32'd0);
    chk("clr_flags", {28'd0, borrow, zero, negative, overflow}, 32'd0);
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("clr_hold_out_valid", {31'd0, out_valid}, 32'd0);
    clear = 1'b0;
    valid_seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) valid_seen++;
    end
    chk("clr_discarded", valid_seen, 32'd0);

    a = 32'h0000_0009; b = 32'h0000_000C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < int'(L); c++) begin
      tick();
      chk($sformatf("post_clr_early_c%0d", c), {31'd0, out_valid}, 32'd0);
    end
    tick();
    chk("post_clr_out_valid", {31'd0, out_valid}, 32'd1);
    chk("post_clr_diff", diff, 32'hFFFF_FFFD);
    chk("post_clr_flags", {28'd0, borrow, zero, negative, overflow}, 32'b1010);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
